// File: rtl/mcast_inject_ni.sv
// Multicast injection NI: sends one header plus payload flits into a router
// local port under credit flow control, then collects one ack per destination.
//
// Handshakes: req, data and ack transfer on a rising clk edge where valid and
// ready are both high (ack has no ready; it is always sampled). flit_valid is a
// push that cannot be refused; the credit counter alone guards it.
module mcast_inject_ni #(
    parameter int FLIT_W  = 64,
    parameter int LEN_W   = 4,
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_mask,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [3:0]        req_tag,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [FLIT_W-1:0] data_flit,
    output logic              flit_valid,
    output logic [FLIT_W-1:0] flit_data,
    output logic              flit_last,
    input  logic              credit_ret,
    input  logic              ack_valid,
    input  logic [2:0]        ack_port,
    input  logic [3:0]        ack_tag,
    output logic              done_valid,
    output logic [3:0]        done_tag,
    output logic              done_err,
    output logic              busy,
    output logic [2:0]        dbg_state,
    output logic [7:0]        dbg_credit
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);
    localparam int HDR_SHIFT = FLIT_W - 9 - LEN_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAD = 3'd1;
    localparam logic [2:0] S_BODY = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_credit;
    logic [4:0]       r_mask;
    logic [4:0]       r_pend;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat;
    logic [3:0]       r_tag;
    logic             r_err;
    logic [TW-1:0]    r_timer;

    logic              w_has_credit;
    logic              w_head_fire;
    logic              w_beat_fire;
    logic              w_fire;
    logic              w_last_beat;
    logic              w_ack_phase;
    logic [4:0]        w_port_oh;
    logic              w_ack_ok;
    logic [4:0]        w_pend_nxt;
    logic [FLIT_W-1:0] w_hdr;

    assign w_has_credit = (r_credit != '0);
    assign w_head_fire  = (r_state == S_HEAD) && w_has_credit;
    assign w_beat_fire  = (r_state == S_BODY) && w_has_credit && data_valid;
    assign w_fire       = w_head_fire || w_beat_fire;
    assign w_last_beat  = (r_beat == r_len - LEN_W'(1));
    assign w_ack_phase  = (r_state == S_HEAD) || (r_state == S_BODY) || (r_state == S_WAIT);

    // Ports 5..7 do not exist; their one-hot is empty so they can never match pend.
    assign w_port_oh  = (ack_port <= 3'd4) ? (5'b00001 << ack_port) : 5'b00000;
    assign w_ack_ok   = (ack_tag == r_tag) && ((w_port_oh & r_pend) != 5'b00000);
    assign w_pend_nxt = (ack_valid && w_ack_phase && w_ack_ok) ? (r_pend & ~w_port_oh) : r_pend;

    assign w_hdr = FLIT_W'({r_mask, r_len, r_tag}) << HDR_SHIFT;

    assign req_ready  = (r_state == S_IDLE);
    assign data_ready = (r_state == S_BODY) && w_has_credit;
    assign flit_valid = w_fire;
    assign flit_data  = w_head_fire ? w_hdr : (w_beat_fire ? data_flit : '0);
    assign flit_last  = (w_head_fire && (r_len == '0)) || (w_beat_fire && w_last_beat);
    assign done_valid = (r_state == S_DONE);
    assign done_tag   = (r_state == S_DONE) ? r_tag : 4'd0;
    assign done_err   = (r_state == S_DONE) && r_err;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;
    assign dbg_credit = 8'(r_credit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credit <= CMAX;
        end else if (w_fire && !credit_ret) begin
            r_credit <= r_credit - CW'(1);
        end else if (credit_ret && !w_fire && (r_credit != CMAX)) begin
            r_credit <= r_credit + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_pend  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_tag   <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            if (w_ack_phase && ack_valid) begin
                if (w_ack_ok) begin
                    r_pend <= w_pend_nxt;
                end else begin
                    r_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mask  <= req_mask;
                        r_pend  <= req_mask;
                        r_len   <= req_len;
                        r_tag   <= req_tag;
                        r_beat  <= '0;
                        r_err   <= (req_mask == 5'b00000);
                        r_state <= (req_mask == 5'b00000) ? S_DONE : S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (w_head_fire) begin
                        r_beat  <= '0;
                        r_timer <= '0;
                        r_state <= (r_len == '0) ? S_WAIT : S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_beat_fire) begin
                        r_beat <= r_beat + LEN_W'(1);
                        if (w_last_beat) begin
                            r_timer <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    // An ack arriving this cycle that empties pend beats the timeout.
                    if (w_pend_nxt == 5'b00000) begin
                        r_state <= S_DONE;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcast_inject_ni.sv
// Bench for mcast_inject_ni: directed scenarios plus random transactions,
// checked against a router/credit/packet model kept here.
module tb_mcast_inject_ni;

    localparam int FLIT_W  = 64;
    localparam int LEN_W   = 4;
    localparam int CREDITS = 4;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_mask;
    logic [LEN_W-1:0]  req_len;
    logic [3:0]        req_tag;
    logic              data_valid;
    logic              data_ready;
    logic [FLIT_W-1:0] data_flit;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_data;
    logic              flit_last;
    logic              credit_ret;
    logic              ack_valid;
    logic [2:0]        ack_port;
    logic [3:0]        ack_tag;
    logic              done_valid;
    logic [3:0]        done_tag;
    logic              done_err;
    logic              busy;
    logic [2:0]        dbg_state;
    logic [7:0]        dbg_credit;

    mcast_inject_ni #(
        .FLIT_W(FLIT_W), .LEN_W(LEN_W), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask),
        .req_len(req_len), .req_tag(req_tag),
        .data_valid(data_valid), .data_ready(data_ready), .data_flit(data_flit),
        .flit_valid(flit_valid), .flit_data(flit_data), .flit_last(flit_last),
        .credit_ret(credit_ret),
        .ack_valid(ack_valid), .ack_port(ack_port), .ack_tag(ack_tag),
        .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err),
        .busy(busy), .dbg_state(dbg_state), .dbg_credit(dbg_credit)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [FLIT_W:0]   exp_q[$];
    logic [FLIT_W-1:0] pay_q[$];
    logic [3:0]        done_tag_q[$];
    logic              done_err_q[$];
    int                done_cyc_q[$];

    int m_credit       = CREDITS;
    int fifo_cnt       = 0;
    int cr_manual      = 0;
    bit auto_cr        = 1'b1;
    bit gap_en         = 1'b0;
    bit beat_taken     = 1'b0;
    int n_flits        = 0;
    int pkt_flits      = 0;
    int first_flit_cyc = 0;
    int last_flit_cyc  = 0;
    int last_ack_cyc   = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    initial forever begin
        @(posedge clk);
        #3;
        if (cr_manual > 0) begin
            credit_ret = 1'b1;
            cr_manual--;
        end else begin
            credit_ret = auto_cr && (fifo_cnt > 0) && ($urandom_range(0, 1) == 1);
        end
    end

    initial forever begin
        @(posedge clk);
        if (beat_taken && pay_q.size() > 0) void'(pay_q.pop_front());
        #2;
        if (pay_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            data_valid = 1'b1;
            data_flit  = pay_q[0];
        end else begin
            data_valid = 1'b0;
            data_flit  = {$urandom, $urandom};
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        logic [FLIT_W:0] e;
        @(negedge clk);
        beat_taken = rst_n && data_valid && data_ready;
        if (!rst_n) begin
            m_credit = CREDITS;
        end else begin
            check_eq("credit", 64'(dbg_credit), 64'(m_credit));
            if (flit_valid) begin
                check_eq("flit_with_credit", 64'(m_credit != 0), 64'd1);
                check_eq("flit_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("flit_data", flit_data, e[FLIT_W-1:0]);
                    check_eq("flit_last", 64'(flit_last), 64'(e[FLIT_W]));
                end
                if (pkt_flits == 0) first_flit_cyc = cyc;
                last_flit_cyc = cyc;
                pkt_flits++;
                n_flits++;
                fifo_cnt++;
            end
            if (credit_ret && fifo_cnt > 0) fifo_cnt--;
            if (flit_valid && !credit_ret) m_credit--;
            else if (credit_ret && !flit_valid && m_credit < CREDITS) m_credit++;
            if (done_valid) begin
                done_tag_q.push_back(done_tag);
                done_err_q.push_back(done_err);
                done_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- transaction tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input logic [4:0] mask, input logic [LEN_W-1:0] len,
                          input logic [3:0] tag, output int t_acc);
        logic [63:0]       hdr;
        logic [FLIT_W-1:0] beat;
        int                n;
        pkt_flits = 0;
        if (mask != 5'd0) begin
            hdr = (64'(mask) << (FLIT_W - 5)) | (64'(len) << (FLIT_W - 5 - LEN_W))
                | (64'(tag) << (FLIT_W - 9 - LEN_W));
            exp_q.push_back({(len == 0), hdr});
            for (int i = 0; i < int'(len); i++) begin
                beat = {$urandom, $urandom};
                pay_q.push_back(beat);
                exp_q.push_back({(i == int'(len) - 1), beat});
            end
        end
        req_valid = 1'b1;
        req_mask  = mask;
        req_len   = len;
        req_tag   = tag;
        n = 0;
        while (!req_ready && n < 200) begin
            step(1);
            n++;
        end
        check_eq("req_ready_wait", 64'(req_ready), 64'd1);
        t_acc = cyc;
        step(1);
        req_valid = 1'b0;
        req_mask  = 5'($urandom);
        req_len   = LEN_W'($urandom);
        req_tag   = 4'($urandom);
    endtask

    task automatic send_ack(input int port, input logic [3:0] tag);
        ack_valid    = 1'b1;
        ack_port     = 3'(port);
        ack_tag      = tag;
        last_ack_cyc = cyc;
        step(1);
        ack_valid = 1'b0;
        ack_port  = 3'($urandom);
        ack_tag   = 4'($urandom);
    endtask

    task automatic wait_done(input int budget, output logic [3:0] tag, output logic err,
                             output int dcyc);
        int n = 0;
        while (done_tag_q.size() == 0 && n < budget) begin
            step(1);
            n++;
        end
        check_eq("done_seen", 64'(done_tag_q.size() != 0), 64'd1);
        if (done_tag_q.size() != 0) begin
            tag  = done_tag_q.pop_front();
            err  = done_err_q.pop_front();
            dcyc = done_cyc_q.pop_front();
        end else begin
            tag  = 4'hx;
            err  = 1'bx;
            dcyc = -1;
        end
    endtask

    task automatic wait_flits(input int target, input int budget);
        int n = 0;
        while (pkt_flits < target && n < budget) begin
            step(1);
            n++;
        end
        check_eq("flit_count_reached", 64'(pkt_flits), 64'(target));
    endtask

    task automatic wait_credits_full();
        int n = 0;
        auto_cr = 1'b1;
        while (m_credit != CREDITS && n < 200) begin
            step(1);
            n++;
        end
        check_eq("credits_refilled", 64'(dbg_credit), 64'(CREDITS));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int         t, t2, t_rel, dcyc, n0, nb;
        logic [3:0] dtag;
        logic       derr;
        logic [4:0] mask;
        logic [3:0] tag;
        int         len;
        int         ports[$];

        rst_n = 1'b0; req_valid = 1'b0; req_mask = '0; req_len = '0; req_tag = '0;
        ack_valid = 1'b0; ack_port = '0; ack_tag = '0;
        data_valid = 1'b0; data_flit = '0; credit_ret = 1'b0;

        // Reset state
        step(3);
        rst_n = 1'b1;
        check_eq("rst_flit_valid", 64'(flit_valid), 64'd0);
        check_eq("rst_data_ready", 64'(data_ready), 64'd0);
        check_eq("rst_done_valid", 64'(done_valid), 64'd0);
        check_eq("rst_done_err", 64'(done_err), 64'd0);
        check_eq("rst_done_tag", 64'(done_tag), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_flit_last", 64'(flit_last), 64'd0);
        check_eq("rst_flit_data", flit_data, 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_credit", 64'(dbg_credit), 64'(CREDITS));

        // Single-flit unicast, ack two cycles after the header
        wait_credits_full();
        do_req(5'b00001, 4'd0, 4'd3, t);
        step(2);
        send_ack(0, 4'd3);
        wait_done(20, dtag, derr, dcyc);
        check_eq("uni_hdr_cycle", 64'(first_flit_cyc), 64'(t + 1));
        check_eq("uni_flits", 64'(pkt_flits), 64'd1);
        check_eq("uni_done_tag", 64'(dtag), 64'd3);
        check_eq("uni_done_err", 64'(derr), 64'd0);
        check_eq("uni_done_cycle", 64'(dcyc), 64'(t + 4));

        // Minimum round trip
        wait_credits_full();
        do_req(5'b00100, 4'd0, 4'd5, t);
        step(1);
        send_ack(2, 4'd5);
        wait_done(20, dtag, derr, dcyc);
        check_eq("rt_done_cycle", 64'(dcyc), 64'(t + 3));
        check_eq("rt_done_err", 64'(derr), 64'd0);

        // Empty mask
        n0 = n_flits;
        do_req(5'b00000, 4'd3, 4'd7, t);
        wait_done(20, dtag, derr, dcyc);
        step(5);
        check_eq("m0_done_cycle", 64'(dcyc), 64'(t + 1));
        check_eq("m0_done_err", 64'(derr), 64'd1);
        check_eq("m0_done_tag", 64'(dtag), 64'd7);
        check_eq("m0_no_flits", 64'(n_flits), 64'(n0));

        // Full fan-out with credit stall
        wait_credits_full();
        auto_cr = 1'b0;
        gap_en  = 1'b0;
        do_req(5'b11111, 4'd6, 4'd9, t);
        step(12);
        check_eq("stall_flits", 64'(pkt_flits), 64'd4);
        check_eq("stall_flit_valid", 64'(flit_valid), 64'd0);
        check_eq("stall_data_ready", 64'(data_ready), 64'd0);
        check_eq("stall_credit", 64'(dbg_credit), 64'd0);
        cr_manual = 3;
        wait_flits(7, 40);
        for (int p = 0; p < 5; p++) send_ack(p, 4'd9);
        wait_done(20, dtag, derr, dcyc);
        check_eq("fan_done_tag", 64'(dtag), 64'd9);
        check_eq("fan_done_err", 64'(derr), 64'd0);
        check_eq("fan_exp_empty", 64'(exp_q.size()), 64'd0);

        // Stray acks during BODY
        wait_credits_full();
        gap_en = 1'b1;
        do_req(5'b00111, 4'd5, 4'd6, t);
        step(1);
        send_ack(2, 4'd6);
        send_ack(2, 4'd6);
        send_ack(0, 4'd7);
        wait_flits(6, 200);
        send_ack(0, 4'd6);
        send_ack(1, 4'd6);
        wait_done(20, dtag, derr, dcyc);
        check_eq("stray_done_tag", 64'(dtag), 64'd6);
        check_eq("stray_done_err", 64'(derr), 64'd1);
        step(20);
        check_eq("stray_no_extra_done", 64'(done_tag_q.size()), 64'd0);

        // Timeout
        wait_credits_full();
        do_req(5'b00110, 4'd2, 4'd10, t);
        wait_flits(3, 200);
        send_ack(1, 4'd10);
        wait_done(60, dtag, derr, dcyc);
        check_eq("to_done_cycle", 64'(dcyc), 64'(last_flit_cyc + 1 + TIMEOUT));
        check_eq("to_done_err", 64'(derr), 64'd1);
        check_eq("to_done_tag", 64'(dtag), 64'd10);

        // credit_ret while already full
        wait_credits_full();
        auto_cr   = 1'b0;
        cr_manual = 2;
        step(4);
        check_eq("sat_credit", 64'(dbg_credit), 64'(CREDITS));

        // Flit and credit_ret in the same cycle
        gap_en = 1'b0;
        do_req(5'b00001, 4'd3, 4'd1, t);
        cr_manual = 1;
        step(1);
        check_eq("simul_hdr_sent", 64'(pkt_flits), 64'd1);
        check_eq("simul_credit", 64'(dbg_credit), 64'(CREDITS));
        auto_cr = 1'b1;
        wait_flits(4, 100);
        send_ack(0, 4'd1);
        wait_done(20, dtag, derr, dcyc);
        check_eq("simul_done_err", 64'(derr), 64'd0);

        // Reset in the middle of BODY
        wait_credits_full();
        auto_cr = 1'b0;
        do_req(5'b00001, 4'd5, 4'd4, t);
        wait_flits(3, 50);
        rst_n = 1'b0;
        pay_q.delete();
        exp_q.delete();
        step(1);
        rst_n    = 1'b1;
        fifo_cnt = 0;
        t_rel    = cyc;
        check_eq("mrst_busy", 64'(busy), 64'd0);
        check_eq("mrst_req_ready", 64'(req_ready), 64'd1);
        check_eq("mrst_credit", 64'(dbg_credit), 64'(CREDITS));
        check_eq("mrst_no_done", 64'(done_tag_q.size()), 64'd0);
        auto_cr = 1'b1;
        do_req(5'b01000, 4'd0, 4'd2, t2);
        check_eq("mrst_accept_cycle", 64'(t2), 64'(t_rel));
        send_ack(3, 4'd2);
        wait_done(20, dtag, derr, dcyc);
        check_eq("mrst_done_tag", 64'(dtag), 64'd2);
        check_eq("mrst_done_err", 64'(derr), 64'd0);

        // Random transactions
        for (int k = 0; k < 12; k++) begin
            mask   = 5'($urandom_range(1, 31));
            len    = int'($urandom_range(0, 15));
            tag    = 4'($urandom);
            gap_en = ($urandom_range(0, 1) == 1);
            do_req(mask, LEN_W'(len), tag, t);
            wait_flits(len + 1, 400);
            ports.delete();
            for (int p = 0; p < 5; p++) if (mask[p]) ports.push_back(p);
            for (int i = ports.size() - 1; i > 0; i--) begin
                int j;
                j        = int'($urandom_range(0, i));
                nb       = ports[i];
                ports[i] = ports[j];
                ports[j] = nb;
            end
            foreach (ports[i]) send_ack(ports[i], tag);
            wait_done(20, dtag, derr, dcyc);
            check_eq("rnd_done_tag", 64'(dtag), 64'(tag));
            check_eq("rnd_done_err", 64'(derr), 64'd0);
            check_eq("rnd_done_cycle", 64'(dcyc), 64'(last_ack_cyc + 1));
            check_eq("rnd_exp_empty", 64'(exp_q.size()), 64'd0);
        end

        step(5);
        check_eq("final_no_extra_done", 64'(done_tag_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mcast_inject_ni.md
# mcast_inject_ni

Multicast injection network interface: the source-side transmitter for `router_cell`'s multicast fan-out. It accepts one multicast request at a time (destination port mask, length, tag) plus payload beats. It emits a header flit and payload flits into the local input port of a `router_cell` under credit-based flow control. It then gathers one acknowledgement per destination port and reports a single completion, with an error flag, to the requester.

## Interface
- FLIT_W, 64: flit width; must be ≥ 13.
- LEN_W, 4: payload-length field width; maximum payload is 2^LEN_W−1 beats.
- CREDITS, 4: depth of the router local-input FIFO; initial credit count.
- TIMEOUT, 1023: number of cycles allowed in WAIT_ACK before an error completion.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high together with req_valid
- req_mask  in  5  destination ports, bit i = router output i
- req_len  in  LEN_W  number of payload beats
- req_tag  in  4  transaction tag
- data_valid  in  1  payload beat offered
- data_ready  out  1  payload beat consumed
- data_flit  in  FLIT_W  payload beat
- flit_valid  out  1  flit pushed into router; no back-pressure other than credits
- flit_data  out  FLIT_W  flit contents
- flit_last  out  1  last flit of the packet
- credit_ret  in  1  pulse: one router FIFO entry freed
- ack_valid  in  1  destination acknowledgement
- ack_port  in  3  acknowledging port, 0–4
- ack_tag  in  4  tag carried by the acknowledgement
- done_valid  out  1  one-cycle completion pulse
- done_tag  out  4  tag of the completed transaction
- done_err  out  1  completion had an error
- busy  out  1  state is not IDLE

## Operation
- **States:** IDLE, HEAD, BODY, WAIT_ACK, DONE.
- **IDLE**
  - req_ready=1.
  - On accept, latch mask, len and tag; set pend=mask and err=0.
  - mask=0: go to DONE with err=1. No flits are sent.
  - Otherwise go to HEAD.
- **HEAD**
  - When credit>0: flit_valid=1.
  - Header layout: flit_data[FLIT_W-1 -: 5]=mask, next LEN_W bits=len, next 4 bits=tag, remaining bits 0.
  - flit_last=(len==0).
  - Go to WAIT_ACK if len==0, else BODY.
- **BODY**
  - data_ready=(credit>0). Each beat with data_valid&&data_ready drives flit_valid=1 and flit_data=data_flit.
  - A beat counter counts up to len. flit_last=1 on beat len; after it, go to WAIT_ACK.
- **Credit counter** (range 0..CREDITS)
  - Decrements on each flit_valid and increments on credit_ret.
  - Both in the same cycle: unchanged.
  - credit_ret when already at CREDITS: saturate and ignore.
- **Acknowledgements**
  - Sampled in HEAD, BODY and WAIT_ACK.
  - A valid ack has ack_tag==tag, ack_port≤4 and pend[ack_port]=1; it clears that pend bit.
  - Any other ack_valid in these states sets err (sticky) and changes nothing else.
  - ack_valid in IDLE or DONE is ignored.
- **WAIT_ACK**
  - A timer is cleared on entry and increments each cycle.
  - pend==0 goes to DONE.
  - Timer reaching TIMEOUT−1 with pend≠0 goes to DONE and sets err=1.
  - pend==0 takes priority over timeout in the same cycle.
- **DONE:** done_valid=1, done_tag=tag, done_err=err; go to IDLE next cycle.

## Timing
- **Reset** (rst_n low at a posedge): state=IDLE, credit=CREDITS, pend=0, err=0, timer=0, beat counter=0.
  - Outputs: flit_valid=0, data_ready=0, done_valid=0, done_err=0, done_tag=0, busy=0, flit_last=0, flit_data=0. req_ready=1 from the first cycle after reset.
  - Reset mid-packet abandons the transaction; no completion is issued.
- **Combinational decodes:** flit_valid, flit_data, flit_last and data_ready decode from registered state, credit and data_valid. flit_valid is never high with credit==0.
- **Latency**
  - Accept at cycle T → header at T+1 if credit>0.
  - Payload beats: one per cycle while data_valid and credit>0.
- **Minimum round trip:** len=0 with an immediately returned ack → done_valid at T+3 (accept, HEAD, WAIT_ACK, DONE).
- **Credits:** credit_ret is usable by a flit in the cycle after it is registered. Credits persist across transactions.
- **Pipelining:** one transaction in flight; no new request is accepted until after the DONE cycle.

## Test plan
- **Single-flit unicast:** mask=00001, len=0, tag=3; ack(port0, tag3) two cycles after the header. Require: one flit with header bits mask=1, len=0, tag=3, flit_last=1; done_valid with tag=3, err=0.
- **Full fan-out with credit stall:** CREDITS=4, mask=11111, len=6, no credit_ret. Require: 4 flits, then flit_valid and data_ready held at 0. Return 3 credits → remaining 3 flits, flit_last on the 7th. Five acks → done err=0.
- **Stray acks:** duplicate ack on port2 and an ack with the wrong tag during BODY. Require: after the remaining valid acks, done_err=1 and no extra completion.
- **Timeout:** mask=00110, only port1 acks, TIMEOUT=16. Require: done_valid exactly 16 cycles after WAIT_ACK entry with done_err=1.
- **Boundary cases:**
  - mask=0: done err=1 at T+1 and zero flits.
  - credit_ret at CREDITS: credit stays 4.
  - Simultaneous flit and credit_ret: credit unchanged.
- **Reset mid-BODY:** assert rst_n=0 after 2 of 5 beats. Require: no done_valid, busy=0, credit=CREDITS, and a new request is accepted on the first cycle after reset.
